// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C EEPROM slave.
// The optional write-protect input is enabled with the I2C_EEPROM_WP_EN macro in the top module.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        ACK_DEV,
        WADDR,
        ACK_WADDR,
        WDATA,
        ACK_WDATA,
        RDATA,
        RACK,
        WAIT_STOP
    } state_t;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'b1010000;

    // Number of word-address bytes the master sends for a given address width.
    function automatic int addr_bytes(input int addr_w);
        return (addr_w + 7) / 8;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into the clk domain and flags SCL edges and START/STOP conditions.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_pipe;
    logic [SYNC_STAGES-1:0] sda_pipe;
    logic                   scl_q;
    logic                   sda_q;

    // Pipes reset to the idle bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_i};
            sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_i};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    assign scl_s    = scl_pipe[SYNC_STAGES-1];
    assign sda_s    = sda_pipe[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_q;
    assign scl_fall = ~scl_s & scl_q;

    // SCL must be high on both samples so skew around an SCL edge is not mistaken for START/STOP.
    assign start = scl_s & scl_q & sda_q & ~sda_s;
    assign stop  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// System-clocked I2C EEPROM slave with multi-byte word address, page writes and sequential reads.
// Define I2C_EEPROM_WP_EN to add the wp input that NACKs and drops data writes.
module i2c_eeprom_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
    parameter int         ADDR_W      = 10,
    parameter int         PAGE_SIZE   = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   scl_i,
    input  logic   sda_i,
`ifdef I2C_EEPROM_WP_EN
    input  logic   wp,
`endif
    output logic   sda_oe,
    output logic   busy,
    output logic   wr_strobe,
    output state_t dbg_state
);

    localparam int NAB = addr_bytes(ADDR_W);
    localparam int BIW = (NAB > 1) ? $clog2(NAB) : 1;
    localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_SIZE - 1);

    logic scl_s, sda_s, scl_rise, scl_fall, start, stop;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_s    (scl_s),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    logic wp_active;
`ifdef I2C_EEPROM_WP_EN
    assign wp_active = wp;
`else
    assign wp_active = 1'b0;
`endif

    logic [7:0] mem [2**ADDR_W];
    logic [7:0] mem_rd;

    state_t            state, state_n;
    logic [3:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        rx, rx_n;
    logic [7:0]        tx, tx_n;
    logic [ADDR_W-1:0] addr_acc, addr_acc_n;
    logic [ADDR_W-1:0] addr_ptr, addr_ptr_n;
    logic [BIW-1:0]    byte_idx, byte_idx_n;
    logic              rw, rw_n;
    logic              wp_lat, wp_lat_n;
    logic              sda_oe_n;
    logic              busy_n;
    logic              mem_we;
    logic [ADDR_W-1:0] page_next;

    assign mem_rd    = mem[addr_ptr];
    assign dbg_state = state;
    // Page writes wrap inside the page; the page-select bits never change.
    assign page_next = (addr_ptr & ~PAGE_MASK) | ((addr_ptr + ADDR_W'(1)) & PAGE_MASK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx        <= '0;
            tx        <= '0;
            addr_acc  <= '0;
            addr_ptr  <= '0;
            byte_idx  <= '0;
            rw        <= 1'b0;
            wp_lat    <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            rx        <= rx_n;
            tx        <= tx_n;
            addr_acc  <= addr_acc_n;
            addr_ptr  <= addr_ptr_n;
            byte_idx  <= byte_idx_n;
            rw        <= rw_n;
            wp_lat    <= wp_lat_n;
            sda_oe    <= sda_oe_n;
            busy      <= busy_n;
            wr_strobe <= mem_we;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[addr_ptr] <= rx;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        rx_n       = rx;
        tx_n       = tx;
        addr_acc_n = addr_acc;
        addr_ptr_n = addr_ptr;
        byte_idx_n = byte_idx;
        rw_n       = rw;
        wp_lat_n   = wp_lat;
        sda_oe_n   = sda_oe;
        busy_n     = busy;
        mem_we     = 1'b0;

        if (stop) begin
            state_n  = IDLE;
            busy_n   = 1'b0;
            sda_oe_n = 1'b0;
        end else if (start) begin
            state_n   = DEV;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end else begin
            case (state)
                DEV, WADDR, WDATA: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        rx_n      = {rx[6:0], sda_s};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        // Byte complete: the ACK slot starts on this falling edge.
                        bit_cnt_n = '0;
                        if (state == DEV) begin
                            if (rx[7:1] == DEV_ADDR) begin
                                state_n  = ACK_DEV;
                                sda_oe_n = 1'b1;
                                busy_n   = 1'b1;
                                rw_n     = rx[0];
                            end else begin
                                state_n = IDLE;
                                busy_n  = 1'b0;
                            end
                        end else if (state == WADDR) begin
                            state_n    = ACK_WADDR;
                            sda_oe_n   = 1'b1;
                            addr_acc_n = ADDR_W'({addr_acc, rx});
                        end else begin
                            state_n  = ACK_WDATA;
                            sda_oe_n = ~wp_active;
                            wp_lat_n = wp_active;
                        end
                    end
                end
                ACK_DEV: begin
                    if (scl_fall) begin
                        bit_cnt_n = '0;
                        if (rw) begin
                            state_n  = RDATA;
                            tx_n     = mem_rd;
                            sda_oe_n = ~mem_rd[7];
                        end else begin
                            state_n    = WADDR;
                            byte_idx_n = '0;
                            sda_oe_n   = 1'b0;
                        end
                    end
                end
                ACK_WADDR: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                        if (byte_idx == BIW'(NAB - 1)) begin
                            state_n    = WDATA;
                            addr_ptr_n = addr_acc;
                        end else begin
                            state_n    = WADDR;
                            byte_idx_n = byte_idx + BIW'(1);
                        end
                    end
                end
                ACK_WDATA: begin
                    if (scl_fall) begin
                        state_n    = WDATA;
                        sda_oe_n   = 1'b0;
                        mem_we     = ~wp_lat;
                        addr_ptr_n = page_next;
                    end
                end
                RDATA: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_n   = RACK;
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                    end else if (scl_fall && bit_cnt != 4'd0) begin
                        sda_oe_n = ~tx[6];
                        tx_n     = tx << 1;
                    end
                end
                RACK: begin
                    // bit_cnt flags that the master ACKed and the next byte is due on the fall.
                    if (scl_rise && bit_cnt == 4'd0) begin
                        if (!sda_s) begin
                            addr_ptr_n = addr_ptr + ADDR_W'(1);
                            bit_cnt_n  = 4'd1;
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        state_n   = RDATA;
                        bit_cnt_n = '0;
                        tx_n      = mem_rd;
                        sda_oe_n  = ~mem_rd[7];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
